// File: rtl/booth_ctrl.sv
// booth_ctrl: sequencer for a radix-2 Booth multiplier datapath.
// Define BOOTH_CTRL_OUTREG_EN to register the product with a valid/ready hold.
module booth_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           dp_clr_n,
    output logic [N-1:0]   dp_A,
    output logic [N-1:0]   dp_B,
    output logic           load_A,
    output logic           load_B,
    output logic           load_add,
    output logic           shift_HQ_LQ_Q_1,
    output logic           add_sub,
    input  logic [1:0]     Q_LSB,
    input  logic [2*N-1:0] Y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        OP,
        SHIFT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;

    logic clr_c, ld_a_c, ld_b_c, ld_add_c, shift_c, add_sub_c;
    logic rdy_raw;
    logic accept;

    assign in_ready = rst & (state_q == IDLE) & rdy_raw;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        clr_c     = 1'b0;
        ld_a_c    = 1'b0;
        ld_b_c    = 1'b0;
        ld_add_c  = 1'b0;
        shift_c   = 1'b0;
        add_sub_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    cnt_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clr_c   = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                ld_a_c  = 1'b1;
                ld_b_c  = 1'b1;
                state_d = OP;
            end
            OP: begin
                // 01 -> add multiplicand, 10 -> subtract, 00/11 -> no-op
                ld_add_c  = Q_LSB[1] ^ Q_LSB[0];
                add_sub_c = (Q_LSB == 2'b01);
                state_d   = SHIFT;
            end
            SHIFT: begin
                shift_c = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(N - 1)) ? DONE : OP;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controls are gated by rst so the datapath sees a clean reset.
    assign dp_clr_n        = rst & ~clr_c;
    assign load_A          = rst & ld_a_c;
    assign load_B          = rst & ld_b_c;
    assign load_add        = rst & ld_add_c;
    assign shift_HQ_LQ_Q_1 = rst & shift_c;
    assign add_sub         = rst & add_sub_c;
    assign busy            = rst & (state_q != IDLE);
    assign dp_A            = a_q;
    assign dp_B            = b_q;

`ifdef BOOTH_CTRL_OUTREG_EN
    logic [2*N-1:0] prod_q, prod_d;
    logic           ov_q, ov_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prod_q <= '0;
            ov_q   <= 1'b0;
        end else begin
            prod_q <= prod_d;
            ov_q   <= ov_d;
        end
    end

    always_comb begin
        prod_d = prod_q;
        ov_d   = ov_q & ~out_ready;
        if (state_q == DONE) begin
            prod_d = Y;
            ov_d   = 1'b1;
        end
    end

    assign rdy_raw   = ~ov_q;
    assign out_valid = rst & ov_q;
    assign product   = prod_q;
`else
    logic unused_out_ready;

    assign unused_out_ready = out_ready;
    assign rdy_raw          = 1'b1;
    assign out_valid        = rst & (state_q == DONE);
    assign product          = rst ? Y : '0;
`endif

endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: directed bench for booth_ctrl with a behavioural
// Booth datapath (N+1-bit accumulator) closing the loop.
module tb_booth_ctrl;

    localparam int N = 8;
`ifdef BOOTH_CTRL_OUTREG_EN
    localparam int LAT = 2 * N + 3;
`else
    localparam int LAT = 2 * N + 2;
`endif

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a_in, b_in;
    logic           dp_clr_n;
    logic [N-1:0]   dp_A, dp_B;
    logic           load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub;
    logic [1:0]     Q_LSB;
    logic [2*N-1:0] Y;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;

    int n_pass = 0;
    int n_chk  = 0;

    booth_ctrl #(.N(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .a_in            (a_in),
        .b_in            (b_in),
        .dp_clr_n        (dp_clr_n),
        .dp_A            (dp_A),
        .dp_B            (dp_B),
        .load_A          (load_A),
        .load_B          (load_B),
        .load_add        (load_add),
        .shift_HQ_LQ_Q_1 (shift_HQ_LQ_Q_1),
        .add_sub         (add_sub),
        .Q_LSB           (Q_LSB),
        .Y               (Y),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .product         (product),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Booth datapath model
    logic signed [N:0] m_q, hq_q;
    logic [N-1:0]      lq_q;
    logic              q1_q;

    always @(posedge clk) begin
        if (!dp_clr_n) begin
            m_q  <= '0;
            hq_q <= '0;
            lq_q <= '0;
            q1_q <= 1'b0;
        end else begin
            if (load_A) m_q <= {dp_A[N-1], dp_A};
            if (load_B) lq_q <= dp_B;
            if (load_add) hq_q <= add_sub ? hq_q + m_q : hq_q - m_q;
            if (shift_HQ_LQ_Q_1) begin
                hq_q <= {hq_q[N], hq_q[N:1]};
                lq_q <= {hq_q[0], lq_q[N-1:1]};
                q1_q <= lq_q[0];
            end
        end
    end

    assign Q_LSB = {lq_q[0], q1_q};
    assign Y     = {hq_q[N-1:0], lq_q};

    // One full transaction; b2b keeps in_valid high with junk operands.
    task automatic mult(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] exp, input string nm,
                        input bit b2b, input int hold);
        int k;
        bit stable;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        k = 0;
        while (in_ready !== 1'b1 && k < 60) begin
            @(posedge clk); #1; k++;
        end
        n_chk++;
        if (in_ready !== 1'b1) begin
            $display("FAIL %s accept_timeout: in_ready=%b want 1", nm, in_ready);
            in_valid = 1'b0;
            return;
        end else n_pass++;
        @(posedge clk); #1;
        if (b2b) begin
            a_in = ~a;
            b_in = ~b;
        end else begin
            in_valid = 1'b0;
        end
        n_chk++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || dp_clr_n !== 1'b0)
            $display("FAIL %s clear_state: busy=%b in_ready=%b dp_clr_n=%b want 1/0/0",
                     nm, busy, in_ready, dp_clr_n);
        else n_pass++;
        n_chk++;
        if (dp_A !== a || dp_B !== b)
            $display("FAIL %s capture: dp_A=%h dp_B=%h want %h %h", nm, dp_A, dp_B, a, b);
        else n_pass++;
        stable = 1'b1;
        k = 0;
        while (out_valid !== 1'b1 && k < LAT + 10) begin
            @(posedge clk); #1; k++;
            if (k == 1) begin
                n_chk++;
                if (load_A !== 1'b1 || load_B !== 1'b1 || dp_clr_n !== 1'b1)
                    $display("FAIL %s load_state: load_A=%b load_B=%b dp_clr_n=%b want 1/1/1",
                             nm, load_A, load_B, dp_clr_n);
                else n_pass++;
            end
            if (out_valid !== 1'b1 && (in_ready !== 1'b0 || dp_A !== a || dp_B !== b))
                stable = 1'b0;
        end
        n_chk++;
        if (k != LAT)
            $display("FAIL %s latency: got %0d edges want %0d", nm, k, LAT);
        else n_pass++;
        n_chk++;
        if (product !== exp)
            $display("FAIL %s product: got %h want %h", nm, product, exp);
        else n_pass++;
        n_chk++;
        if (!stable)
            $display("FAIL %s busy_window: accepted or operands changed while busy (got 0 want 1)", nm);
        else n_pass++;
`ifdef BOOTH_CTRL_OUTREG_EN
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_chk++;
            if (out_valid !== 1'b1 || product !== exp || in_ready !== 1'b0)
                $display("FAIL %s hold%0d: out_valid=%b product=%h in_ready=%b want 1 %h 0",
                         nm, i, out_valid, product, exp, in_ready);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        if (!b2b) out_ready = 1'b0;
`else
        if (hold < 0) out_ready = 1'b0;
        @(posedge clk); #1;
`endif
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s release: out_valid=%b in_ready=%b want 0 1", nm, out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL reset_status: busy=%b in_ready=%b out_valid=%b want 0 0 0",
                     busy, in_ready, out_valid);
        else n_pass++;
        n_chk++;
        if ({load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub} !== 5'b0 || dp_clr_n !== 1'b0)
            $display("FAIL reset_ctrl: ctrls=%b dp_clr_n=%b want 00000 0",
                     {load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub}, dp_clr_n);
        else n_pass++;
        n_chk++;
        if (product !== '0 || dp_A !== '0 || dp_B !== '0)
            $display("FAIL reset_regs: product=%h dp_A=%h dp_B=%h want 0", product, dp_A, dp_B);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1 || dp_clr_n !== 1'b1)
            $display("FAIL reset_release: in_ready=%b dp_clr_n=%b want 1 1", in_ready, dp_clr_n);
        else n_pass++;
    endtask

    task automatic test_basic();
        mult(8'd3, 8'd5, 16'h000F, "3x5", 1'b0, 0);
        mult(8'hFD, 8'd5, 16'hFFF1, "m3x5", 1'b0, 0);
        mult(8'h80, 8'h80, 16'h4000, "m128xm128", 1'b0, 0);
        mult(8'd7, 8'd9, 16'h003F, "7x9", 1'b0, 0);
        mult(8'd0, 8'd9, 16'h0000, "0x9", 1'b0, 0);
        mult(8'd127, 8'h80, 16'hC080, "127xm128", 1'b0, 0);
        mult(8'hFF, 8'hFF, 16'h0001, "m1xm1", 1'b0, 0);
    endtask

    task automatic test_hold();
        mult(8'd12, 8'hFE, 16'hFFE8, "hold_12xm2", 1'b0, 10);
    endtask

    task automatic test_mid_reset();
        a_in     = 8'd9;
        b_in     = 8'd9;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL midrst_pre: busy=%b in_ready=%b want 1 0", busy, in_ready);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0 || dp_clr_n !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL midrst_during: busy=%b dp_clr_n=%b in_ready=%b want 0 0 0",
                     busy, dp_clr_n, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_chk++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || dp_A !== '0)
            $display("FAIL midrst_after: busy=%b in_ready=%b out_valid=%b dp_A=%h want 0 1 0 00",
                     busy, in_ready, out_valid, dp_A);
        else n_pass++;
        mult(8'd2, 8'd3, 16'h0006, "2x3_after_rst", 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        mult(8'd5, 8'd6, 16'h001E, "b2b_5x6", 1'b1, 0);
        mult(8'hF9, 8'd3, 16'hFFEB, "b2b_m7x3", 1'b1, 0);
        mult(8'd127, 8'd127, 16'h3F01, "b2b_127x127", 1'b1, 0);
        mult(8'h80, 8'd1, 16'hFF80, "b2b_m128x1", 1'b1, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/booth_ctrl.md
BOOTH_CTRL -- requirements
Module: booth_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the operand width in bits (N >= 2).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a_in, b_in  input  N each  two's-complement multiplicand and multiplier.
REQ-007 dp_clr_n  output  1  active-low synchronous clear to the Booth datapath.
REQ-008 dp_A, dp_B  output  N each  registered operands to the datapath A and B inputs.
REQ-009 load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub  output  1 each  datapath controls.
REQ-010 Q_LSB  input  2  {LQ[0], Q_1} from the datapath.
REQ-011 Y  input  2N  datapath product {HQ, LQ}.
REQ-012 out_valid  output  1  product valid; out_ready  input  1  consumer accepts; product  output  2N  signed result.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, CLEAR, LOAD, OP, SHIFT and DONE.
REQ-015 IDLE: in_ready=1 (subject to REQ-024); in_valid&&in_ready captures a_in/b_in into dp_A/dp_B, clears the iteration counter and moves to CLEAR.
REQ-016 CLEAR: dp_clr_n=0 for exactly one cycle; next state LOAD.
REQ-017 LOAD: load_A=1 and load_B=1 for one cycle; next state OP.
REQ-018 OP: load_add=Q_LSB[1]^Q_LSB[0]; add_sub=1 when Q_LSB==01 and 0 when Q_LSB==10; add_sub=0 when Q_LSB is 00 or 11; next state SHIFT.
REQ-019 SHIFT: shift_HQ_LQ_Q_1=1 and the counter increments; next state is DONE when the counter was N-1, otherwise OP.
REQ-020 The counter SHALL be $clog2(N)+1 bits wide, so that N iterations never wrap.
REQ-021 DONE: one cycle, completes the result per the Configuration section, then returns to IDLE.
REQ-022 All datapath controls not named for a state SHALL be 0 in that state, and dp_clr_n SHALL be 1.
REQ-023 The product SHALL equal signed(a_in)*signed(b_in) in 2N bits for all operand values, including a_in=0 and -2^(N-1)*-2^(N-1).
REQ-024 in_ready SHALL be IDLE && !out_valid. A new operand pair is never accepted while a result is pending.
REQ-025 in_valid asserted outside IDLE SHALL be ignored. Captured operands SHALL not change until the next accept.

Reset
REQ-026 rst=0 at any clock edge, including mid-operation, SHALL force the state to IDLE, the counter to 0, and dp_A, dp_B and product to 0.
REQ-027 During reset: out_valid=0, busy=0, in_ready=0, and all datapath controls are 0.
REQ-028 dp_clr_n SHALL equal rst while rst=0, so that the datapath is reset with the controller.
REQ-029 The first accept SHALL be possible at the first edge after rst returns to 1.

Configuration
REQ-030 The macro BOOTH_CTRL_OUTREG_EN SHALL select the output-register feature.
REQ-031 Defined: in DONE the product register loads Y, and out_valid rises 2N+3 edges after the accepting edge. out_valid and product then hold until an edge with out_ready=1, which clears out_valid.
REQ-032 Not defined: product=Y combinationally, and out_valid=1 only during the DONE cycle, visible 2N+2 edges after the accept. out_ready is ignored, and in_ready depends only on the IDLE state.

Verification
REQ-033 N=8, a_in=3, b_in=5 -> product=0x000F; out_valid rises at accept+19 edges (OUTREG) or accept+18 edges (no OUTREG).
REQ-034 a_in=-3 (0xFD), b_in=5 -> product=0xFFF1; a_in=-128, b_in=-128 -> product=0x4000.
REQ-035 a_in=0 following a prior 7*9 run -> product=0x0000, which confirms that CLEAR clears the stale multiplicand.
REQ-036 OUTREG: hold out_ready=0 for 10 cycles after out_valid -> product stable and in_ready=0; pulse out_ready -> out_valid falls next edge, and in_ready=1.
REQ-037 rst=0 for one edge in the 4th OP state -> IDLE, busy=0; then 2*3 -> product=0x0006 with nominal latency.
REQ-038 Back-to-back pairs with in_valid held high and out_ready=1 -> each product is correct, with no accept while busy.
